// File: rtl/burst_line_port.sv
// burst_line_port
// Initiator side of the burst RAM interface. Moves one cache line of
// BURST_COUNT words between the host line buffer and a burst-capable RAM.
//
// State table:
//   IDLE     | waiting for start; request fields latched on start
//   ISSUE    | waiting for ram_busy=0, then pulses ram_cmd_en
//   WR_BURST | streams words 1..BURST_COUNT-1, then completes
//   RD_WAIT  | waits for the first valid word, bounded by TIMEOUT cycles
//   RD_BURST | captures words 1..BURST_COUNT-1; a gap in valid is an error
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, write, line_addr      request strobe, direction, line address
//   wr_line / rd_line            packed lines, word k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   busy, done, err              request status
//   ram_cmd, ram_cmd_en,
//   ram_addr, ram_wr_data,
//   ram_data_mask                command/write side towards the RAM
//   ram_rd_data,
//   ram_rd_data_valid, ram_busy  read/status side from the RAM
module burst_line_port #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT    = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int TIMEOUT        = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        write,
    input  logic [DEPTH_BITWIDTH-$clog2(BURST_COUNT)-1:0] line_addr,
    input  logic [DATA_BITWIDTH*BURST_COUNT-1:0]        wr_line,
    output logic [DATA_BITWIDTH*BURST_COUNT-1:0]        rd_line,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        err,
    output logic                                        ram_cmd,
    output logic                                        ram_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]                   ram_addr,
    output logic [DATA_BITWIDTH-1:0]                    ram_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]                  ram_data_mask,
    input  logic [DATA_BITWIDTH-1:0]                    ram_rd_data,
    input  logic                                        ram_rd_data_valid,
    input  logic                                        ram_busy
);

    localparam int WORD_BITS = $clog2(BURST_COUNT);
    localparam int LINE_BITS = DEPTH_BITWIDTH - WORD_BITS;
    localparam int TMR_BITS  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WR_BURST,
        ST_RD_WAIT,
        ST_RD_BURST
    } state_t;

    state_t                     state_q, state_d;
    logic                       write_q, write_d;
    logic [LINE_BITS-1:0]       line_q, line_d;
    logic [DATA_BITWIDTH-1:0]   wr_word_q [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0]   wr_word_d [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0]   rd_word_q [BURST_COUNT];
    logic [DATA_BITWIDTH-1:0]   rd_word_d [BURST_COUNT];
    logic [WORD_BITS-1:0]       word_q, word_d;
    logic [TMR_BITS-1:0]        tmr_q, tmr_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic                       cmd_q, cmd_d;
    logic                       cmd_en_q, cmd_en_d;
    logic [DEPTH_BITWIDTH-1:0]  addr_q, addr_d;
    logic [DATA_BITWIDTH-1:0]   wr_data_q, wr_data_d;

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        line_d    = line_q;
        wr_word_d = wr_word_q;
        rd_word_d = rd_word_q;
        word_d    = word_q;
        tmr_d     = tmr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        cmd_d     = cmd_q;
        cmd_en_d  = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    write_d = write;
                    line_d  = line_addr;
                    for (int k = 0; k < BURST_COUNT; k++) begin
                        wr_word_d[k] = wr_line[k*DATA_BITWIDTH +: DATA_BITWIDTH];
                    end
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ram_busy) begin
                    cmd_en_d  = 1'b1;
                    cmd_d     = write_q;
                    addr_d    = {line_q, {WORD_BITS{1'b0}}};
                    wr_data_d = wr_word_q[0];
                    word_d    = WORD_BITS'(1);
                    tmr_d     = TMR_BITS'(TIMEOUT);
                    state_d   = write_q ? ST_WR_BURST : ST_RD_WAIT;
                end
            end
            ST_WR_BURST: begin
                // word_q wraps to 0 once the last word has been driven
                if (word_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wr_data_d = wr_word_q[word_q];
                    word_d    = word_q + WORD_BITS'(1);
                end
            end
            ST_RD_WAIT: begin
                // A valid word on the final timeout cycle still wins
                if (ram_rd_data_valid) begin
                    rd_word_d[0] = ram_rd_data;
                    word_d       = WORD_BITS'(1);
                    state_d      = ST_RD_BURST;
                end else if (tmr_q == TMR_BITS'(1)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_BITS'(1);
                end
            end
            ST_RD_BURST: begin
                if (ram_rd_data_valid) begin
                    rd_word_d[word_q] = ram_rd_data;
                    word_d            = word_q + WORD_BITS'(1);
                    if (word_q == WORD_BITS'(BURST_COUNT - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            line_q    <= '0;
            wr_word_q <= '{default: '0};
            rd_word_q <= '{default: '0};
            word_q    <= '0;
            tmr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            cmd_q     <= 1'b0;
            cmd_en_q  <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            line_q    <= line_d;
            wr_word_q <= wr_word_d;
            rd_word_q <= rd_word_d;
            word_q    <= word_d;
            tmr_q     <= tmr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            cmd_q     <= cmd_d;
            cmd_en_q  <= cmd_en_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    for (genvar k = 0; k < BURST_COUNT; k++) begin : g_rd_pack
        assign rd_line[k*DATA_BITWIDTH +: DATA_BITWIDTH] = rd_word_q[k];
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ram_cmd       = cmd_q;
    assign ram_cmd_en    = cmd_en_q;
    assign ram_addr      = addr_q;
    assign ram_wr_data   = wr_data_q;
    assign ram_data_mask = '0;

endmodule

// File: tb/tb_burst_line_port.sv
// tb_burst_line_port
// Drives line reads/writes into burst_line_port against a small burst RAM
// responder, and compares every DUT output each cycle with a transaction
// timeline model (accept, command, first-valid and done cycles).
module tb_burst_line_port;

    localparam int DB = 4;
    localparam int BC = 4;
    localparam int DW = 64;
    localparam int TO = 32;
    localparam int LB = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            write = 1'b0;
    logic [LB-1:0]   line_addr = '0;
    logic [DW*BC-1:0] wr_line = '0;
    logic [DW*BC-1:0] rd_line;
    logic            busy, done, err, ram_cmd, ram_cmd_en;
    logic [DB-1:0]   ram_addr;
    logic [DW-1:0]   ram_wr_data;
    logic [DW/8-1:0] ram_data_mask;
    logic [DW-1:0]   ram_rd_data = '0;
    logic            ram_rd_data_valid = 1'b0;
    logic            ram_busy = 1'b0;

    burst_line_port #(
        .DEPTH_BITWIDTH(DB), .BURST_COUNT(BC), .DATA_BITWIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .write(write),
        .line_addr(line_addr), .wr_line(wr_line), .rd_line(rd_line),
        .busy(busy), .done(done), .err(err),
        .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
        .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
        .ram_busy(ram_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction timeline model ----------------
    int  cyc = 0;
    bit  seen_rst = 1'b1;
    bit  started = 1'b0;
    bit  t_act = 1'b0;
    int  t_s, t_c, t_f, t_d;
    bit  t_err, t_write;
    logic [LB-1:0] t_line;
    logic [DW-1:0] t_w [BC];
    logic [DW-1:0] m_rd [BC];
    int  mn, mk;

    initial for (int k = 0; k < BC; k++) m_rd[k] = '0;

    always @(posedge clk) begin
        mn = cyc;
        seen_rst = rst;
        started = 1'b1;
        if (rst) begin
            t_act = 1'b0;
            for (int k = 0; k < BC; k++) m_rd[k] = '0;
        end else if (!t_act || (t_d >= 0 && mn >= t_d)) begin
            if (start) begin
                t_act = 1'b1; t_s = mn; t_c = -1; t_f = -1; t_d = -1; t_err = 1'b0;
                t_write = write; t_line = line_addr;
                for (int k = 0; k < BC; k++) t_w[k] = wr_line[k*DW +: DW];
            end
        end else if (t_d < 0) begin
            if (t_c < 0) begin
                if (!ram_busy) begin
                    t_c = mn + 1;
                    if (t_write) t_d = t_c + BC;
                end
            end else if (!t_write) begin
                if (t_f < 0) begin
                    if (ram_rd_data_valid) begin
                        t_f = mn; m_rd[0] = ram_rd_data;
                    end else if (mn == t_c + TO - 1) begin
                        t_d = mn + 1; t_err = 1'b1;
                    end
                end else begin
                    mk = mn - t_f;
                    if (ram_rd_data_valid) begin
                        m_rd[mk] = ram_rd_data;
                        if (mk == BC - 1) t_d = mn + 1;
                    end else begin
                        t_d = mn + 1; t_err = 1'b1;
                    end
                end
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    logic [DW*BC-1:0] exp_rd;
    int cm;
    always @(negedge clk) begin
        if (started) begin
            cm = cyc;
            for (int k = 0; k < BC; k++) exp_rd[k*DW +: DW] = m_rd[k];
            check("busy", 256'(busy), 256'(t_act && (t_d < 0 || cm < t_d)));
            check("done", 256'(done), 256'(t_act && cm == t_d));
            check("err", 256'(err), 256'(t_act && t_d >= 0 && cm >= t_d && t_err));
            check("cmd_en", 256'(ram_cmd_en), 256'(t_act && cm == t_c));
            check("mask", 256'(ram_data_mask), 256'(0));
            check("rd_line", 256'(rd_line), 256'(exp_rd));
            if (t_act && cm == t_c) begin
                check("ram_cmd", 256'(ram_cmd), 256'(t_write));
                check("ram_addr", 256'(ram_addr), 256'({t_line, 2'b00}));
            end
            if (t_act && t_write && t_c >= 0 && cm >= t_c && cm < t_c + BC)
                check("wr_data", 256'(ram_wr_data), 256'(t_w[cm - t_c]));
        end
    end

    // ---------------- burst RAM responder ----------------
    logic [DW-1:0] mem [16];
    logic [DW-1:0] sb_mem [16];
    int  r_mode = 0, r_lat = 10, r_drop = 2, r_extra = 1;
    bit  r_noise = 1'b0;
    bit  r_act = 1'b0, r_write;
    int  r_c, r_end, r_nv, r_addr, rm, rk;

    initial for (int i = 0; i < 16; i++) begin mem[i] = '0; sb_mem[i] = '0; end

    always @(negedge clk) begin
        rm = cyc;
        ram_rd_data_valid = 1'b0;
        ram_rd_data = {$urandom, $urandom};
        if (seen_rst) begin
            r_act = 1'b0;
            ram_busy = 1'b0;
        end else begin
            if (ram_cmd_en) begin
                r_act = 1'b1; r_c = rm; r_write = ram_cmd; r_addr = int'(ram_addr);
                if (r_write) begin
                    r_nv = 0; r_end = rm + BC - 1 + r_extra;
                end else if (r_mode == 1) begin
                    r_nv = 0; r_end = rm + 3;
                end else if (r_mode == 2) begin
                    r_nv = r_drop; r_end = rm + r_lat + r_drop + r_extra;
                end else begin
                    r_nv = BC; r_end = rm + r_lat + BC - 1 + r_extra;
                end
            end
            if (r_act) begin
                rk = rm - r_c;
                if (r_write && rk < BC) mem[r_addr + rk] = ram_wr_data;
                if (!r_write && rk - r_lat >= 0 && rk - r_lat < r_nv) begin
                    ram_rd_data_valid = 1'b1;
                    ram_rd_data = mem[r_addr + rk - r_lat];
                end
                ram_busy = (rm <= r_end);
                if (rm >= r_end) r_act = 1'b0;
            end else begin
                ram_busy = r_noise && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req(input bit wr, input logic [LB-1:0] la, input logic [255:0] ln,
                       input bit spur, output bit e, output int ncmd, output int sc,
                       output int cc, output int dc, output logic [DB-1:0] ca, output bit ccmd);
        e = 1'b0; ncmd = 0; cc = -1; dc = -1; ca = '0; ccmd = 1'b0;
        @(negedge clk);
        start = 1'b1; write = wr; line_addr = la; wr_line = ln; sc = cyc;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            write = 1'($urandom);
            line_addr = LB'($urandom);
            wr_line = {8{$urandom}};
            if (ram_cmd_en) begin
                ncmd++;
                if (cc < 0) begin cc = cyc; ca = ram_addr; ccmd = ram_cmd; end
            end
            if (done) begin dc = cyc; e = err; break; end
            if (spur && busy && $urandom_range(0, 7) == 0) start = 1'b1;
        end
        check("req_completes", 256'(dc >= 0), 256'(1));
    endtask

    function automatic logic [255:0] mk_line(input logic [63:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [255:0] sb_line(input int la);
        return {sb_mem[la*4+3], sb_mem[la*4+2], sb_mem[la*4+1], sb_mem[la*4]};
    endfunction

    initial begin
        bit e, cmdv, seen;
        int nc, sc, cc, dc;
        logic [DB-1:0] ca;
        logic [255:0] ln;
        bit wr;
        logic [LB-1:0] la;

        repeat (3) @(negedge clk);
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check("rst_cmd_en", 256'(ram_cmd_en), 256'(0));
        check("rst_addr", 256'(ram_addr), 256'(0));
        check("rst_wr_data", 256'(ram_wr_data), 256'(0));
        check("rst_rd_line", 256'(rd_line), 256'(0));
        rst = 1'b0;

        // write line 1
        r_extra = 1;
        req(1'b1, 2'd1, mk_line(64'h11, 64'h22, 64'h33, 64'h44), 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("w1_err", 256'(e), 256'(0));
        check("w1_ncmd", 256'(nc), 256'(1));
        check("w1_addr", 256'(ca), 256'(4));
        check("w1_cmd", 256'(cmdv), 256'(1));
        check("w1_latency", 256'(dc - sc), 256'(6));
        for (int k = 0; k < 4; k++) sb_mem[4 + k] = 64'(64'h11 * (k + 1));

        // read line 1 with 10-cycle response delay; long trailing busy afterwards
        r_extra = 3; r_lat = 10;
        req(1'b0, 2'd1, '0, 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("r1_err", 256'(e), 256'(0));
        check("r1_latency", 256'(dc - sc), 256'(16));
        check("r1_line", 256'(rd_line), 256'(mk_line(64'h11, 64'h22, 64'h33, 64'h44)));

        // back-to-back write while the RAM is still busy
        r_extra = 1;
        req(1'b1, 2'd2, mk_line(64'hA0, 64'hA1, 64'hA2, 64'hA3), 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("b2b_err", 256'(e), 256'(0));
        check("b2b_latency", 256'(dc - sc), 256'(7));
        check("b2b_ncmd", 256'(nc), 256'(1));
        check("b2b_mem", 256'({mem[11], mem[10], mem[9], mem[8]}),
              256'(mk_line(64'hA0, 64'hA1, 64'hA2, 64'hA3)));
        for (int k = 0; k < 4; k++) sb_mem[8 + k] = 64'(64'hA0 + k);

        // responder that never returns data
        r_mode = 1;
        req(1'b0, 2'd0, '0, 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("to_err", 256'(e), 256'(1));
        check("to_ncmd", 256'(nc), 256'(1));
        check("to_wait", 256'(dc - cc), 256'(32));
        check("to_line_kept", 256'(rd_line), 256'(mk_line(64'h11, 64'h22, 64'h33, 64'h44)));
        r_mode = 0;

        // valid dropped after 2 words
        req(1'b0, 2'd2, '0, 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("r2_line", 256'(rd_line), 256'(mk_line(64'hA0, 64'hA1, 64'hA2, 64'hA3)));
        req(1'b1, 2'd3, mk_line(64'hB0, 64'hB1, 64'hB2, 64'hB3), 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        for (int k = 0; k < 4; k++) sb_mem[12 + k] = 64'(64'hB0 + k);
        r_mode = 2; r_drop = 2;
        req(1'b0, 2'd3, '0, 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("drop_err", 256'(e), 256'(1));
        check("drop_line", 256'(rd_line), 256'(mk_line(64'hB0, 64'hB1, 64'hA2, 64'hA3)));
        r_mode = 0;

        // reset during a write burst, after word 1
        @(negedge clk);
        start = 1'b1; write = 1'b1; line_addr = 2'd0;
        wr_line = mk_line(64'hC0, 64'hC1, 64'hC2, 64'hC3);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_cmd_en) begin seen = 1'b1; break; end
        end
        check("rstw_cmd_seen", 256'(seen), 256'(1));
        @(negedge clk);
        check("rstw_word1", 256'(ram_wr_data), 256'(64'hC1));
        rst = 1'b1;
        @(negedge clk);
        check("rstw_busy", 256'(busy), 256'(0));
        check("rstw_cmd_en", 256'(ram_cmd_en), 256'(0));
        check("rstw_wr_data", 256'(ram_wr_data), 256'(0));
        check("rstw_addr", 256'(ram_addr), 256'(0));
        check("rstw_rd_line", 256'(rd_line), 256'(0));
        rst = 1'b0;
        sb_mem[0] = 64'hC0; sb_mem[1] = 64'hC1;
        repeat (4) begin
            @(negedge clk);
            check("rstw_no_done", 256'(done), 256'(0));
        end
        req(1'b0, 2'd1, '0, 1'b0, e, nc, sc, cc, dc, ca, cmdv);
        check("rstw_read_err", 256'(e), 256'(0));
        check("rstw_read_line", 256'(rd_line), 256'(mk_line(64'h11, 64'h22, 64'h33, 64'h44)));

        // randomized traffic
        r_noise = 1'b1;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom);
            la = LB'($urandom);
            ln = {8{$urandom}};
            r_lat = $urandom_range(1, 12);
            r_extra = $urandom_range(1, 3);
            r_mode = 0;
            if (!wr) begin
                case ($urandom_range(0, 9))
                    0: r_mode = 1;
                    1: begin r_mode = 2; r_drop = $urandom_range(1, 3); end
                    default: r_mode = 0;
                endcase
            end
            req(wr, la, ln, 1'b1, e, nc, sc, cc, dc, ca, cmdv);
            check("rnd_ncmd", 256'(nc), 256'(1));
            check("rnd_err", 256'(e), 256'(!wr && r_mode != 0));
            if (wr) begin
                for (int k = 0; k < 4; k++) sb_mem[la*4 + k] = ln[k*DW +: DW];
            end else if (r_mode == 0) begin
                check("rnd_sb_line", 256'(rd_line), 256'(sb_line(int'(la))));
            end
        end
        r_noise = 1'b0;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
